// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 receive path.
// Scancode prefixes, game key codes and the frame FSM state encoding.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    localparam logic [7:0] KEY_W = 8'h1D;
    localparam logic [7:0] KEY_S = 8'h1B;
    localparam logic [7:0] KEY_O = 8'h44;
    localparam logic [7:0] KEY_L = 8'h4B;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PS2_BREAK) || (b == PS2_EXT);
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Synchronizes the raw PS/2 pins, debounces the clock line and
// produces a one-cycle strobe on each filtered falling edge.
module ps2_sync_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic iCLK_50,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic dat_s,
    output logic fall
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic          r_clk_meta;
    logic          r_clk_sync;
    logic          r_dat_meta;
    logic          r_dat_sync;
    logic          r_clk_filt;
    logic [CW-1:0] r_cnt;
    logic          r_fall;

    logic w_differ;
    logic w_flip;

    assign w_differ = (r_clk_sync != r_clk_filt);
    assign w_flip   = w_differ && (r_cnt == CNT_LAST);

    always_ff @(posedge iCLK_50 or negedge reset) begin
        if (!reset) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
            r_clk_filt <= 1'b1;
            r_cnt      <= '0;
            r_fall     <= 1'b0;
        end else begin
            r_clk_meta <= ps2_clk;
            r_clk_sync <= r_clk_meta;
            r_dat_meta <= ps2_dat;
            r_dat_sync <= r_dat_meta;
            // any sample matching the filtered level restarts the run
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_cnt      <= '0;
                r_clk_filt <= ~r_clk_filt;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_fall <= w_flip && r_clk_filt;
        end
    end

    assign dat_s = r_dat_sync;
    assign fall  = r_fall;

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: deserializes 11-bit frames, checks
// start/parity/stop, and decodes F0/E0 prefixes into scancode events.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       iCLK_50,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       code_valid,
    output logic [7:0] code,
    output logic       code_break,
    output logic       code_ext,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] T_LIMIT = TW'(TIMEOUT_CYC);

    logic w_dat;
    logic w_fall;

    ps2_sync_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_sync_filter (
        .iCLK_50 (iCLK_50),
        .reset   (reset),
        .ps2_clk (ps2_clk),
        .ps2_dat (ps2_dat),
        .dat_s   (w_dat),
        .fall    (w_fall)
    );

    ps2_state_e    r_state;
    ps2_state_e    w_state_next;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic          r_par;
    logic [TW-1:0] r_tcnt;
    logic          r_break_pend;
    logic          r_ext_pend;

    logic       r_byte_valid;
    logic [7:0] r_byte_data;
    logic       r_code_valid;
    logic [7:0] r_code;
    logic       r_code_break;
    logic       r_code_ext;
    logic       r_parity_err;
    logic       r_frame_err;

    logic w_frame_done;
    logic w_timeout;
    logic w_parity_ok;
    logic w_good;
    logic w_perr;
    logic w_ferr;

    // a fall in the same cycle as the limit restarts the count instead
    assign w_timeout = (r_state != IDLE) && !w_fall && (r_tcnt == T_LIMIT);

    always_comb begin
        w_state_next = r_state;
        w_frame_done = 1'b0;
        case (r_state)
            IDLE:    if (w_fall && !w_dat) w_state_next = DATA;
            DATA:    if (w_fall && (r_bitcnt == 3'd7)) w_state_next = PARITY;
            PARITY:  if (w_fall) w_state_next = STOP;
            STOP: begin
                if (w_fall) begin
                    w_state_next = IDLE;
                    w_frame_done = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
        if (w_timeout) w_state_next = IDLE;
    end

    assign w_parity_ok = ^{r_shift, r_par};
    assign w_good      = w_frame_done && w_dat && w_parity_ok;
    assign w_perr      = w_frame_done && w_dat && !w_parity_ok;
    assign w_ferr      = (w_frame_done && !w_dat) || w_timeout;

    always_ff @(posedge iCLK_50 or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge iCLK_50 or negedge reset) begin
        if (!reset) begin
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_tcnt   <= '0;
        end else begin
            if (w_fall) begin
                case (r_state)
                    IDLE:   r_bitcnt <= '0;
                    DATA: begin
                        r_shift  <= {w_dat, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 1'b1;
                    end
                    PARITY: r_par <= w_dat;
                    default: ;
                endcase
            end
            if (w_fall || (r_state == IDLE) || w_timeout) begin
                r_tcnt <= '0;
            end else begin
                r_tcnt <= r_tcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge iCLK_50 or negedge reset) begin
        if (!reset) begin
            r_byte_valid <= 1'b0;
            r_byte_data  <= '0;
            r_code_valid <= 1'b0;
            r_code       <= '0;
            r_code_break <= 1'b0;
            r_code_ext   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_break_pend <= 1'b0;
            r_ext_pend   <= 1'b0;
        end else begin
            r_byte_valid <= w_good;
            r_code_valid <= w_good && !is_prefix(r_shift);
            r_parity_err <= w_perr;
            r_frame_err  <= w_ferr;
            if (w_good) begin
                r_byte_data <= r_shift;
                if (r_shift == PS2_BREAK) begin
                    r_break_pend <= 1'b1;
                end else if (r_shift == PS2_EXT) begin
                    r_ext_pend <= 1'b1;
                end else begin
                    r_code       <= r_shift;
                    r_code_break <= r_break_pend;
                    r_code_ext   <= r_ext_pend;
                    r_break_pend <= 1'b0;
                    r_ext_pend   <= 1'b0;
                end
            end else if (w_perr || w_ferr) begin
                r_break_pend <= 1'b0;
                r_ext_pend   <= 1'b0;
            end
        end
    end

    assign byte_valid = r_byte_valid;
    assign byte_data  = r_byte_data;
    assign code_valid = r_code_valid;
    assign code       = r_code;
    assign code_break = r_code_break;
    assign code_ext   = r_code_ext;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed bench for ps2_rx_frame: drives PS/2 frames bit by bit and
// checks pulse counts and held outputs against hand-computed values.
module tb_ps2_rx_frame;

    localparam int HALF = 20;
    localparam int TOUT = 1000;

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       code_valid;
    logic [7:0] code;
    logic       code_break;
    logic       code_ext;
    logic       parity_err;
    logic       frame_err;

    int n_checks = 0;
    int n_pass   = 0;
    int n_bv = 0, n_cv = 0, n_pe = 0, n_fe = 0;

    ps2_rx_frame #(
        .FILTER_LEN  (8),
        .TIMEOUT_CYC (TOUT)
    ) dut (
        .iCLK_50    (clk),
        .reset      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .code_valid (code_valid),
        .code       (code),
        .code_break (code_break),
        .code_ext   (code_ext),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (byte_valid) n_bv <= n_bv + 1;
        if (code_valid) n_cv <= n_cv + 1;
        if (parity_err) n_pe <= n_pe + 1;
        if (frame_err)  n_fe <= n_fe + 1;
    end

    function automatic logic [10:0] mk(input logic [7:0] d, input logic p, input logic s);
        return {s, p, d, 1'b0};
    endfunction

    // sends the first n bits of frame f (bit 0 = start bit)
    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_dat = f[i];
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
    endtask

    task automatic settle();
        repeat (30) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({byte_valid, byte_data, code_valid, code, code_break, code_ext, parity_err, frame_err} !== 22'd0)
            $display("FAIL reset_outputs: got %h required 0",
                {byte_valid, byte_data, code_valid, code, code_break, code_ext, parity_err, frame_err});
        else n_pass++;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_single_make();
        int b0, c0;
        b0 = n_bv; c0 = n_cv;
        send_bits(mk(8'h1D, 1'b1, 1'b1), 11);
        settle();
        n_checks++;
        if (n_bv - b0 !== 1) $display("FAIL make_bv_count: got %0d required 1", n_bv - b0); else n_pass++;
        n_checks++;
        if (byte_data !== 8'h1D) $display("FAIL make_byte_data: got %h required 1d", byte_data); else n_pass++;
        n_checks++;
        if (n_cv - c0 !== 1) $display("FAIL make_cv_count: got %0d required 1", n_cv - c0); else n_pass++;
        n_checks++;
        if ({code, code_break, code_ext} !== {8'h1D, 1'b0, 1'b0})
            $display("FAIL make_code: got %h/%b/%b required 1d/0/0", code, code_break, code_ext);
        else n_pass++;
    endtask

    task automatic test_break();
        int b0, c0;
        b0 = n_bv; c0 = n_cv;
        send_bits(mk(8'hF0, 1'b1, 1'b1), 11);
        send_bits(mk(8'h1D, 1'b1, 1'b1), 11);
        settle();
        n_checks++;
        if (n_bv - b0 !== 2) $display("FAIL break_bv_count: got %0d required 2", n_bv - b0); else n_pass++;
        n_checks++;
        if (n_cv - c0 !== 1) $display("FAIL break_cv_count: got %0d required 1", n_cv - c0); else n_pass++;
        n_checks++;
        if ({code, code_break, code_ext} !== {8'h1D, 1'b1, 1'b0})
            $display("FAIL break_code: got %h/%b/%b required 1d/1/0", code, code_break, code_ext);
        else n_pass++;
    endtask

    task automatic test_ext_break();
        int b0, c0;
        b0 = n_bv; c0 = n_cv;
        send_bits(mk(8'hE0, 1'b0, 1'b1), 11);
        send_bits(mk(8'hF0, 1'b1, 1'b1), 11);
        send_bits(mk(8'h75, 1'b0, 1'b1), 11);
        settle();
        n_checks++;
        if (n_bv - b0 !== 3) $display("FAIL ext_bv_count: got %0d required 3", n_bv - b0); else n_pass++;
        n_checks++;
        if (n_cv - c0 !== 1) $display("FAIL ext_cv_count: got %0d required 1", n_cv - c0); else n_pass++;
        n_checks++;
        if ({code, code_break, code_ext} !== {8'h75, 1'b1, 1'b1})
            $display("FAIL ext_code: got %h/%b/%b required 75/1/1", code, code_break, code_ext);
        else n_pass++;
        send_bits(mk(8'h1D, 1'b1, 1'b1), 11);
        settle();
        n_checks++;
        if ({code, code_break, code_ext} !== {8'h1D, 1'b0, 1'b0})
            $display("FAIL ext_pend_cleared: got %h/%b/%b required 1d/0/0", code, code_break, code_ext);
        else n_pass++;
    endtask

    task automatic test_parity_error();
        int b0, c0, p0, f0;
        send_bits(mk(8'hF0, 1'b1, 1'b1), 11);
        settle();
        b0 = n_bv; c0 = n_cv; p0 = n_pe; f0 = n_fe;
        send_bits(mk(8'h44, 1'b0, 1'b1), 11);
        settle();
        n_checks++;
        if (n_pe - p0 !== 1) $display("FAIL parity_err_count: got %0d required 1", n_pe - p0); else n_pass++;
        n_checks++;
        if (n_fe - f0 !== 0) $display("FAIL parity_no_frame_err: got %0d required 0", n_fe - f0); else n_pass++;
        n_checks++;
        if ((n_bv - b0) + (n_cv - c0) !== 0)
            $display("FAIL parity_dropped: got %0d required 0", (n_bv - b0) + (n_cv - c0));
        else n_pass++;
        send_bits(mk(8'h44, 1'b1, 1'b1), 11);
        settle();
        n_checks++;
        if (n_cv - c0 !== 1) $display("FAIL parity_recover_cv: got %0d required 1", n_cv - c0); else n_pass++;
        n_checks++;
        if ({code, code_break, code_ext} !== {8'h44, 1'b0, 1'b0})
            $display("FAIL parity_recover_code: got %h/%b/%b required 44/0/0", code, code_break, code_ext);
        else n_pass++;
    endtask

    task automatic test_stop_error();
        int b0, p0, f0;
        b0 = n_bv; p0 = n_pe; f0 = n_fe;
        // stop 0 and parity 0 on 0x1D: both bad, only frame_err expected
        send_bits(mk(8'h1D, 1'b0, 1'b0), 11);
        settle();
        n_checks++;
        if (n_fe - f0 !== 1) $display("FAIL stop_frame_err: got %0d required 1", n_fe - f0); else n_pass++;
        n_checks++;
        if (n_pe - p0 !== 0) $display("FAIL stop_no_parity_err: got %0d required 0", n_pe - p0); else n_pass++;
        n_checks++;
        if (n_bv - b0 !== 0) $display("FAIL stop_dropped: got %0d required 0", n_bv - b0); else n_pass++;
    endtask

    task automatic test_timeout();
        int f0, c0;
        f0 = n_fe;
        send_bits(mk(8'h4B, 1'b1, 1'b1), 5);
        repeat (TOUT - 100) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (n_fe - f0 !== 0) $display("FAIL timeout_early: got %0d required 0", n_fe - f0); else n_pass++;
        repeat (200) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (n_fe - f0 !== 1) $display("FAIL timeout_frame_err: got %0d required 1", n_fe - f0); else n_pass++;
        c0 = n_cv;
        send_bits(mk(8'h4B, 1'b1, 1'b1), 11);
        settle();
        n_checks++;
        if (n_fe - f0 !== 1) $display("FAIL timeout_once: got %0d required 1", n_fe - f0); else n_pass++;
        n_checks++;
        if (n_cv - c0 !== 1 || code !== 8'h4B)
            $display("FAIL timeout_recover: got cv %0d code %h required 1/4b", n_cv - c0, code);
        else n_pass++;
    endtask

    task automatic test_glitch();
        int b0, c0, p0, f0;
        b0 = n_bv; c0 = n_cv; p0 = n_pe; f0 = n_fe;
        @(posedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        ps2_clk = 1'b1;
        settle();
        n_checks++;
        if ((n_bv - b0) + (n_cv - c0) + (n_pe - p0) + (n_fe - f0) !== 0)
            $display("FAIL glitch_pulses: got %0d required 0",
                (n_bv - b0) + (n_cv - c0) + (n_pe - p0) + (n_fe - f0));
        else n_pass++;
        send_bits(mk(8'h1B, 1'b1, 1'b1), 11);
        settle();
        n_checks++;
        if (n_bv - b0 !== 1 || byte_data !== 8'h1B)
            $display("FAIL glitch_state: got bv %0d data %h required 1/1b", n_bv - b0, byte_data);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int b0, c0;
        b0 = n_bv; c0 = n_cv;
        send_bits(mk(8'hE0, 1'b0, 1'b1), 11);
        send_bits(mk(8'h4B, 1'b1, 1'b1), 11);
        send_bits(mk(8'h1D, 1'b1, 1'b1), 11);
        settle();
        n_checks++;
        if (n_bv - b0 !== 3 || n_cv - c0 !== 2)
            $display("FAIL b2b_counts: got bv %0d cv %0d required 3/2", n_bv - b0, n_cv - c0);
        else n_pass++;
        n_checks++;
        if ({code, code_break, code_ext} !== {8'h1D, 1'b0, 1'b0})
            $display("FAIL b2b_code: got %h/%b/%b required 1d/0/0", code, code_break, code_ext);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        int b0, f0;
        send_bits(mk(8'h44, 1'b1, 1'b1), 5);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({byte_valid, byte_data, code_valid, code, code_break, code_ext, parity_err, frame_err} !== 22'd0)
            $display("FAIL midreset_outputs: got %h required 0",
                {byte_valid, byte_data, code_valid, code, code_break, code_ext, parity_err, frame_err});
        else n_pass++;
        f0 = n_fe; b0 = n_bv;
        rst_n = 1'b1;
        repeat (TOUT + 100) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ((n_fe - f0) + (n_bv - b0) !== 0)
            $display("FAIL midreset_release_pulse: got %0d required 0", (n_fe - f0) + (n_bv - b0));
        else n_pass++;
        send_bits(mk(8'h1B, 1'b1, 1'b1), 11);
        settle();
        n_checks++;
        if (n_bv - b0 !== 1 || {code, code_break, code_ext} !== {8'h1B, 1'b0, 1'b0})
            $display("FAIL midreset_recover: got bv %0d code %h/%b/%b required 1 1b/0/0",
                n_bv - b0, code, code_break, code_ext);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_make();
        test_break();
        test_ext_break();
        test_parity_error();
        test_stop_error();
        test_timeout();
        test_glitch();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_rx_frame.md
Name: ps2_rx_frame

Overview:
Upstream receive stage for the PS/2 keyboard path. It synchronizes and filters raw `ps2_clk`/`ps2_dat`, deserializes 11-bit device-to-host frames, and checks parity, start and stop bits. It delivers validated bytes, plus decoded make/break/extended scancode events, to the key-tracking / paddle-control logic. It is receive-only: the host never drives `ps2_dat`.

Parameters:
- FILTER_LEN, 8: consecutive identical samples required before the filtered `ps2_clk` changes level.
- TIMEOUT_CYC, 100000: `iCLK_50` cycles without a filtered falling edge mid-frame before the frame is aborted (2 ms at 50 MHz). Counter width is $clog2(TIMEOUT_CYC+1).

Ports:
- iCLK_50  in  1  system clock, 50 MHz; the single clock domain.
- reset  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2_dat  in  1  raw PS/2 data pin, asynchronous.
- byte_valid  out  1  one-cycle pulse per good frame, including F0/E0 prefixes.
- byte_data  out  8  last good byte; holds until the next byte_valid.
- code_valid  out  1  one-cycle pulse per complete scancode event (non-prefix byte).
- code  out  8  scancode of the last event; holds.
- code_break  out  1  last event was preceded by F0 (key release); holds.
- code_ext  out  1  last event was preceded by E0; holds.
- parity_err  out  1  one-cycle pulse when a frame has bad parity.
- frame_err  out  1  one-cycle pulse on bad start/stop bit or timeout.

Behaviour:
- Reset values:
  - All outputs 0.
  - Sync flops and filtered clock = 1.
  - FSM = IDLE, pend flags = 0, counters = 0.
- Input conditioning:
  - 2-flop synchronizers on both pins.
  - The filtered clock toggles only after FILTER_LEN consecutive samples differ from its current value.
  - fall = filtered clock 1->0, registered as a one-cycle strobe.
  - Data is sampled (synchronized `ps2_dat`) in the fall cycle.
- FSM states, advancing only on fall:
  - IDLE: dat=0 -> DATA, bitcnt=0. dat=1 -> stay in IDLE, no error.
  - DATA: shift right, new bit into MSB (LSB-first), bitcnt++. After the 8th bit -> PARITY.
  - PARITY: capture parity bit -> STOP.
  - STOP: always -> IDLE. Frame is good iff dat=1 and XOR(data, parity)=1 (odd parity).
    - Parity bad -> parity_err.
    - Stop bad -> frame_err. If both are bad, assert frame_err only.
- Outputs for a good frame:
  - byte_valid and byte_data update in the cycle after the stop-bit fall strobe (latency 1).
  - Decode, evaluated in that same cycle:
    - F0: set break_pend.
    - E0: set ext_pend.
    - Other byte: code_valid=1, code=byte, code_break=break_pend, code_ext=ext_pend, then clear both pend flags.
- Error handling: any error drops the byte, clears both pend flags, and emits no byte_valid or code_valid.
- Timeout:
  - The counter clears on every fall and counts while FSM != IDLE.
  - On reaching TIMEOUT_CYC: FSM -> IDLE, frame_err pulse, pend flags cleared.
  - Fall and timeout in the same cycle: fall wins, counter clears, no error.
- Reset asserted mid-frame aborts immediately. No pulse is emitted on deassertion.
- Back-to-back frames need no idle gap beyond the stop bit.

Decomposition:
- Package ps2_pkg:
  - Constants PS2_BREAK=8'hF0 and PS2_EXT=8'hE0.
  - Game key codes KEY_W=8'h1D, KEY_S=8'h1B, KEY_O=8'h44, KEY_L=8'h4B.
  - FSM state typedef {IDLE, DATA, PARITY, STOP}.
- One sub-module, ps2_sync_filter (instantiated once):
  - Contents: synchronizers + glitch filter + fall-edge strobe.
  - Outputs: dat_s, fall.

Test Plan:
- Frame 0x1D (start 0, bits LSB-first, parity 1, stop 1) -> byte_valid with byte_data=0x1D; code_valid with code=0x1D, code_break=0, code_ext=0.
- Frames F0 (parity 1), then 1D -> byte_valid twice; code_valid once with code=0x1D, code_break=1, code_ext=0.
- Frames E0 (parity 0), F0, 75 (parity 0) -> single code_valid with code=0x75, code_ext=1, code_break=1; pend flags clear afterwards.
- Frame 0x44 with parity 0 -> parity_err pulse, no byte_valid. Following 0x44 with parity 1 -> code_valid with code=0x44, code_break=0.
- Stop after 4 data bits, idle >100000 cycles -> frame_err exactly once at the timeout. Next good 0x4B frame -> code_valid with code=0x4B.
- 3-cycle low glitch on ps2_clk while idle -> no state change, no pulses. Reset asserted mid-frame -> all outputs 0; the next full frame decodes correctly.
